// File: rtl/mst_min_stream_if.sv
// Stream handshake bundle for mst_min_stream: element input channel and result output channel.
interface mst_min_stream_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
);
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic              i_last;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_min;
    logic [IDX_W-1:0]  o_idx;
    logic [IDX_W:0]    o_cnt;
    logic              o_ovf;

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_min, o_idx, o_cnt, o_ovf
    );

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_min, o_idx, o_cnt, o_ovf
    );
endinterface

// File: rtl/mst_min_stream.sv
// Streaming frame minimum finder: reports min value, first index of the min, saturating
// element count and an overflow flag once per frame.
module mst_min_stream #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    mst_min_stream_if.slave  bus
);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_OUT} state_e;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic in_beat;
    logic out_beat;
    logic pos_ovf;
    logic new_min;

    assign in_beat  = bus.i_valid & ready_q;
    assign out_beat = valid_q & bus.i_ready;
    // cnt_q equals the position of the incoming element; its top bit marks positions >= 2^IDX_W
    assign pos_ovf  = cnt_q[IDX_W];
    assign new_min  = bus.i_data < min_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_beat) state_d = bus.i_last ? ST_OUT : ST_ACC;
            ST_ACC:  if (in_beat && bus.i_last) state_d = ST_OUT;
            ST_OUT:  if (out_beat) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        min_d   = min_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ready_d = (state_d != ST_OUT);
        valid_d = (state_d == ST_OUT);
        case (state_q)
            ST_IDLE: begin
                if (in_beat) begin
                    min_d = bus.i_data;
                    idx_d = '0;
                    cnt_d = CNT_W'(1);
                    ovf_d = 1'b0;
                end
            end
            ST_ACC: begin
                if (in_beat) begin
                    if (new_min) begin
                        min_d = bus.i_data;
                        idx_d = pos_ovf ? '1 : cnt_q[IDX_W-1:0];
                    end
                    if (pos_ovf) ovf_d = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Handshake flags come up only on the first edge after reset release
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            min_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ready_q <= ready_d;
            valid_q <= valid_d;
            min_q   <= min_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_min   = min_q;
    assign bus.o_idx   = idx_q;
    assign bus.o_cnt   = cnt_q;
    assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_mst_min_stream.sv
// Self-checking bench for mst_min_stream: directed frames plus randomized frames against a frame-level model.
module tb_mst_min_stream;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam int          IDX_LIM = 2 ** IDX_W;
    localparam int          CNT_MAX = 2 ** (IDX_W + 1) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mst_min_stream_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    mst_min_stream #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Frame-level reference: first index of the minimum, clamped to all-ones past the index range
    function automatic void model(input int q[$], output int m, output int ix, output int c, output bit ov);
        m  = q[0];
        ix = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] < m) begin
                m  = q[i];
                ix = i;
            end
        end
        if (ix >= IDX_LIM) ix = IDX_LIM - 1;
        c  = (q.size() > CNT_MAX) ? CNT_MAX : q.size();
        ov = (q.size() > IDX_LIM);
    endfunction

    task automatic send_elem(input logic [7:0] d, input bit last, input bit gaps);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.i_valid = 1'b0;
            end else begin
                bus.i_valid = 1'b1;
                bus.i_data  = d;
                bus.i_last  = last;
                acc = (bus.o_ready === 1'b1);
            end
            guard++;
            if (!acc && guard > 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: o_ready=%b required 1 within 100 cycles", bus.o_ready);
                acc = 1'b1;
            end
        end
    endtask

    task automatic send_frame(input int q[$], input bit gaps);
        for (int i = 0; i < q.size(); i++)
            send_elem(8'(q[i]), (i == q.size() - 1), gaps);
    endtask

    task automatic recv(input string name, input int em, input int ei, input int ec, input bit eo, input bit rnd);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        @(negedge clk);
        bus.i_valid = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: o_valid=%b required 1", name, bus.o_valid);
        end
        while (!done) begin
            checks++;
            if (bus.o_min !== 8'(em) || bus.o_idx !== 4'(ei) || bus.o_cnt !== 5'(ec) || bus.o_ovf !== eo ||
                bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold: min=%0d idx=%0d cnt=%0d ovf=%b v=%b r=%b required min=%0d idx=%0d cnt=%0d ovf=%b v=1 r=0",
                         name, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf, bus.o_valid, bus.o_ready, em, ei, ec, eo);
            end
            bus.i_ready = (rnd && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk);
            if (bus.i_ready) done = 1'b1;
            @(negedge clk);
            guard++;
        end
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_min !== 8'(em) || bus.o_idx !== 4'(ei) ||
            bus.o_cnt !== 5'(ec) || bus.o_ovf !== eo) begin
            errors++;
            $display("FAIL %s_post: v=%b r=%b min=%0d idx=%0d cnt=%0d ovf=%b required v=0 r=1 min=%0d idx=%0d cnt=%0d ovf=%b",
                     name, bus.o_valid, bus.o_ready, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf, em, ei, ec, eo);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state: r=%b v=%b min=%0d idx=%0d cnt=%0d ovf=%b required all 0",
                     bus.o_ready, bus.o_valid, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: o_ready=%b required 0", bus.o_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: r=%b v=%b required r=1 v=0", bus.o_ready, bus.o_valid);
        end
    endtask

    task automatic test_basic();
        send_frame('{5, 3, 9, 3}, 1'b0);
        recv("basic", 3, 1, 4, 1'b0, 1'b0);
    endtask

    task automatic test_single();
        send_frame('{255}, 1'b0);
        recv("single_ff", 255, 0, 1, 1'b0, 1'b0);
        send_frame('{0}, 1'b0);
        recv("single_00", 0, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_ovf();
        int q[$];
        for (int v = 20; v >= 3; v--) q.push_back(v);
        send_frame(q, 1'b0);
        recv("ovf", 3, 15, 18, 1'b1, 1'b0);
        send_frame('{10, 12}, 1'b0);
        recv("ovf_clear", 10, 0, 2, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        send_frame('{4, 2}, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_min !== 8'd2 || bus.o_idx !== 4'd1 ||
                bus.o_cnt !== 5'd2 || bus.o_ovf !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: v=%b r=%b min=%0d idx=%0d cnt=%0d ovf=%b required v=1 r=0 min=2 idx=1 cnt=2 ovf=0",
                         k, bus.o_valid, bus.o_ready, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf);
            end
            bus.i_valid = 1'b1;
            bus.i_data  = 8'($urandom_range(0, 1));
            bus.i_last  = 1'b1;
            bus.i_ready = 1'b0;
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_min !== 8'd2 || bus.o_cnt !== 5'd2) begin
            errors++;
            $display("FAIL stall_release: v=%b r=%b min=%0d cnt=%0d required v=0 r=1 min=2 cnt=2",
                     bus.o_valid, bus.o_ready, bus.o_min, bus.o_cnt);
        end
        send_frame('{50}, 1'b0);
        recv("after_stall", 50, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midframe();
        send_elem(8'd9, 1'b0, 1'b0);
        send_elem(8'd8, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_ready, bus.o_valid, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf} !== '0) begin
            errors++;
            $display("FAIL midframe_reset: r=%b v=%b min=%0d idx=%0d cnt=%0d ovf=%b required all 0",
                     bus.o_ready, bus.o_valid, bus.o_min, bus.o_idx, bus.o_cnt, bus.o_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL midframe_no_valid_%0d: o_valid=%b required 0", k, bus.o_valid);
            end
        end
        send_frame('{7}, 1'b0);
        recv("after_reset", 7, 0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int q[$];
        int m, ix, c, len;
        bit ov;
        for (int f = 0; f < 1000; f++) begin
            q.delete();
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++)
                q.push_back(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255)));
            model(q, m, ix, c, ov);
            send_frame(q, 1'b1);
            recv("random", m, ix, c, ov, 1'b1);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_ovf();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
